// File: rtl/uram_timer_pkg.sv
// Shared types, helpers and parameter guard for the URAM fractional capture timer.
`ifndef URAM_TIMER_PKG_SV
`define URAM_TIMER_PKG_SV

// Elaboration-time parameter guard: only elaborates an error block when cond is false.
`define URAM_TIMER_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end

package uram_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } timer_state_t;

  // Accumulator must hold acc + CAP_NUM, which is below 2*CAP_DEN.
  function automatic int acc_width(input int den);
    return $clog2(den) + 1;
  endfunction

endpackage

`endif

// File: rtl/uram_timer_chan_dly.sv
// Per-channel delay line carrying the {start, capture} strobe pair DEPTH clocks late.
module uram_timer_chan_dly
  import uram_timer_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic capture,
  output logic start_dly,
  output logic capture_dly,
  output logic pending
);

  logic [DEPTH-1:0] start_sr;
  logic [DEPTH-1:0] capture_sr;

  // Both strobes shift one stage per clock; reset flushes anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sr   <= '0;
      capture_sr <= '0;
    end else begin
      start_sr[0]   <= start;
      capture_sr[0] <= capture;
      for (int i = 1; i < DEPTH; i++) begin
        start_sr[i]   <= start_sr[i-1];
        capture_sr[i] <= capture_sr[i-1];
      end
    end
  end

  assign start_dly   = start_sr[DEPTH-1];
  assign capture_dly = capture_sr[DEPTH-1];

  // Any stage occupied, including the one currently on the output.
  assign pending = (|start_sr) | (|capture_sr);

endmodule

// File: rtl/uram_frac_capture_timer.sv
// Fractional-rate capture strobe generator: CAP_NUM strobes per CAP_DEN memclk cycles,
// phase-aligned start, per-channel staggered copies, capture counter and clean drain.
module uram_frac_capture_timer
  import uram_timer_pkg::*;
#(
  parameter int CAP_NUM  = 3,
  parameter int CAP_DEN  = 16,
  parameter int INIT_ACC = 0,
  parameter int NCHAN    = 8,
  parameter int CHAN_DLY = 1,
  parameter int CNT_W    = 12
) (
  input  logic             memclk_i,
  input  logic             memrst_i,
  input  logic             memclk_phase_i,
  input  logic             running_i,
  output logic [NCHAN-1:0] start_o,
  output logic [NCHAN-1:0] capture_o,
  output logic [CNT_W-1:0] capture_count_o,
  output logic             busy_o
);

  localparam int ACC_W = acc_width(CAP_DEN);
  localparam logic [ACC_W-1:0] NUM_V  = ACC_W'(CAP_NUM);
  localparam logic [ACC_W-1:0] DEN_V  = ACC_W'(CAP_DEN);
  localparam logic [ACC_W-1:0] INIT_V = ACC_W'(INIT_ACC);

  `URAM_TIMER_CHECK(g_chk_num, (CAP_NUM >= 1) && (CAP_NUM < CAP_DEN), "CAP_NUM must be in 1 .. CAP_DEN-1")
  `URAM_TIMER_CHECK(g_chk_den, (CAP_DEN >= 2) && (CAP_DEN <= 256), "CAP_DEN must be in 2 .. 256")
  `URAM_TIMER_CHECK(g_chk_init, (INIT_ACC >= 0) && (INIT_ACC < CAP_DEN), "INIT_ACC must be below CAP_DEN")
  `URAM_TIMER_CHECK(g_chk_nchan, (NCHAN >= 1) && (NCHAN <= 16), "NCHAN must be in 1 .. 16")
  `URAM_TIMER_CHECK(g_chk_dly, (CHAN_DLY >= 0) && (CHAN_DLY <= 4), "CHAN_DLY must be in 0 .. 4")
  `URAM_TIMER_CHECK(g_chk_cnt, CNT_W >= 1, "CNT_W must be at least 1")

  timer_state_t     state;
  logic             prev_run;
  logic             rise;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] count;
  logic             start0;
  logic             cap0;
  logic [NCHAN-1:0] pend;
  logic             any_pending;

  assign rise        = running_i & ~prev_run;
  assign acc_sum     = acc + NUM_V;
  assign any_pending = |pend;

  // Busy covers the whole run plus the time delayed copies are still emerging.
  assign busy_o = (state == S_RUN) | any_pending;

  // Control FSM with registered channel-0 strobes, Bresenham accumulator and counter.
  always_ff @(posedge memclk_i) begin
    if (memrst_i) begin
      state    <= S_IDLE;
      prev_run <= 1'b0;
      acc      <= '0;
      count    <= '0;
      start0   <= 1'b0;
      cap0     <= 1'b0;
    end else begin
      prev_run <= running_i;
      start0   <= 1'b0;
      cap0     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise) state <= S_ARM;
        end
        S_ARM: begin
          if (!running_i) begin
            state <= S_IDLE;
          end else if (memclk_phase_i && !busy_o) begin
            state  <= S_RUN;
            start0 <= 1'b1;
            cap0   <= 1'b1;
            acc    <= INIT_V;
            count  <= CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!running_i) begin
            state <= S_DRAIN;
          end else if (acc_sum >= DEN_V) begin
            cap0  <= 1'b1;
            acc   <= acc_sum - DEN_V;
            count <= count + CNT_W'(1);
          end else begin
            acc <= acc_sum;
          end
        end
        S_DRAIN: begin
          if (rise) begin
            state <= S_ARM;
          end else if (!any_pending) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign start_o[0]      = start0;
  assign capture_o[0]    = cap0;
  assign pend[0]         = 1'b0;
  assign capture_count_o = count;

  // Each channel k is tapped from channel 0 with its own k*CHAN_DLY line.
  for (genvar k = 1; k < NCHAN; k++) begin : g_chan
    if (CHAN_DLY == 0) begin : g_copy
      assign start_o[k]   = start0;
      assign capture_o[k] = cap0;
      assign pend[k]      = 1'b0;
    end else begin : g_dly
      uram_timer_chan_dly #(
        .DEPTH(k * CHAN_DLY)
      ) u_dly (
        .clk        (memclk_i),
        .rst        (memrst_i),
        .start      (start0),
        .capture    (cap0),
        .start_dly  (start_o[k]),
        .capture_dly(capture_o[k]),
        .pending    (pend[k])
      );
    end
  end

endmodule
